// File: rtl/mc_ctrl_pkg.sv
// Shared encodings for the multi-cycle controller: states, opcodes,
// funct codes, ALU operations and datapath mux selects.
package mc_ctrl_pkg;

  typedef enum logic [3:0] {
    S_IF      = 4'd0,
    S_ID      = 4'd1,
    S_MEMADR  = 4'd2,
    S_MEMRD   = 4'd3,
    S_MEMWB   = 4'd4,
    S_MEMWR   = 4'd5,
    S_EXE     = 4'd6,
    S_ALUWB   = 4'd7,
    S_BRANCH  = 4'd8,
    S_JUMP    = 4'd9,
    S_ADDI_EX = 4'd10,
    S_ADDI_WB = 4'd11
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_AND = 6'h24;
  localparam logic [5:0] FN_OR  = 6'h25;
  localparam logic [5:0] FN_SLT = 6'h2A;

  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_SLT = 3'b111;

  localparam logic [1:0] SRCB_REG    = 2'b00;
  localparam logic [1:0] SRCB_FOUR   = 2'b01;
  localparam logic [1:0] SRCB_IMM    = 2'b10;
  localparam logic [1:0] SRCB_IMM_SH = 2'b11;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

endpackage

// File: rtl/mc_ctrl_fsm_if.sv
// Controller <-> datapath bundle: instruction fields and status in,
// strobes and mux selects out.
interface mc_ctrl_fsm_if;
  logic [5:0] opcode;
  logic [5:0] funct;
  logic       zero;
  logic       mem_ready;
  logic       pc_write;
  logic       pc_write_cond;
  logic       iord;
  logic       mem_read;
  logic       mem_write;
  logic       ir_write;
  logic       mem_to_reg;
  logic       reg_dst;
  logic       reg_write;
  logic       alu_src_a;
  logic [1:0] alu_src_b;
  logic [1:0] pc_source;
  logic [2:0] alu_ctrl;
  logic       instr_done;
  logic       illegal;

  modport master (
    input  opcode, funct, zero, mem_ready,
    output pc_write, pc_write_cond, iord, mem_read, mem_write, ir_write,
           mem_to_reg, reg_dst, reg_write, alu_src_a, alu_src_b, pc_source,
           alu_ctrl, instr_done, illegal
  );

  modport slave (
    output opcode, funct, zero, mem_ready,
    input  pc_write, pc_write_cond, iord, mem_read, mem_write, ir_write,
           mem_to_reg, reg_dst, reg_write, alu_src_a, alu_src_b, pc_source,
           alu_ctrl, instr_done, illegal
  );
endinterface

// File: rtl/mc_alu_dec.sv
// R-type funct decoder: ALU operation plus a flag for supported functs.
module mc_alu_dec
  import mc_ctrl_pkg::*;
(
  input  logic [5:0] funct,
  output logic [2:0] alu_ctrl,
  output logic       funct_legal
);

  // Map funct to ALU op; unsupported functs fall back to add and flag illegal.
  always_comb begin
    alu_ctrl    = ALU_ADD;
    funct_legal = 1'b1;
    case (funct)
      FN_ADD:  alu_ctrl = ALU_ADD;
      FN_SUB:  alu_ctrl = ALU_SUB;
      FN_AND:  alu_ctrl = ALU_AND;
      FN_OR:   alu_ctrl = ALU_OR;
      FN_SLT:  alu_ctrl = ALU_SLT;
      default: funct_legal = 1'b0;
    endcase
  end

endmodule

// File: rtl/mc_ctrl_fsm.sv
// Multi-cycle datapath sequencer.
//   state     | meaning
//   S_IF      | fetch; wait for memory, load IR, PC += 4
//   S_ID      | decode; branch target into ALUOut; flag unsupported ops
//   S_MEMADR  | compute load/store address
//   S_MEMRD   | load data read, wait for memory
//   S_MEMWB   | write loaded data to rt
//   S_MEMWR   | store data write, wait for memory
//   S_EXE     | R-type ALU operation
//   S_ALUWB   | write ALU result to rd
//   S_BRANCH  | compare, conditional PC load
//   S_JUMP    | PC load from jump target
//   S_ADDI_EX | addi ALU operation
//   S_ADDI_WB | write addi result to rt
module mc_ctrl_fsm
  import mc_ctrl_pkg::*;
#(
  parameter int STATE_W = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  mc_ctrl_fsm_if.master      bus,
  output logic [STATE_W-1:0] state
);

  state_t     state_q;
  logic [2:0] dec_alu;
  logic       dec_legal;
  logic       id_illegal;

  logic pc_write_c, pc_write_cond_c, ir_write_c, reg_write_c;
  logic mem_read_c, mem_write_c, instr_done_c, illegal_c;

  // zero only matters to the datapath, which qualifies pc_write_cond with it.
  logic unused_zero;
  assign unused_zero = bus.zero;

  mc_alu_dec u_alu_dec (
    .funct      (bus.funct),
    .alu_ctrl   (dec_alu),
    .funct_legal(dec_legal)
  );

  // Decide whether the instruction held in IR is supported.
  always_comb begin
    id_illegal = 1'b1;
    case (bus.opcode)
      OP_LW, OP_SW, OP_BEQ, OP_J, OP_ADDI: id_illegal = 1'b0;
      OP_RTYPE:                            id_illegal = !dec_legal;
      default:                             id_illegal = 1'b1;
    endcase
  end

  // State register and transitions; memory states hold until mem_ready.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IF;
    end else begin
      case (state_q)
        S_IF:      if (bus.mem_ready) state_q <= S_ID;
        S_ID: begin
          case (bus.opcode)
            OP_LW, OP_SW: state_q <= S_MEMADR;
            OP_RTYPE:     state_q <= dec_legal ? S_EXE : S_IF;
            OP_BEQ:       state_q <= S_BRANCH;
            OP_J:         state_q <= S_JUMP;
            OP_ADDI:      state_q <= S_ADDI_EX;
            default:      state_q <= S_IF;
          endcase
        end
        S_MEMADR:  state_q <= (bus.opcode == OP_LW) ? S_MEMRD : S_MEMWR;
        S_MEMRD:   if (bus.mem_ready) state_q <= S_MEMWB;
        S_MEMWR:   if (bus.mem_ready) state_q <= S_IF;
        S_EXE:     state_q <= S_ALUWB;
        S_ADDI_EX: state_q <= S_ADDI_WB;
        default:   state_q <= S_IF;
      endcase
    end
  end

  // Decode strobes and selects from the current state (mem_ready-gated where noted).
  always_comb begin
    pc_write_c      = 1'b0;
    pc_write_cond_c = 1'b0;
    ir_write_c      = 1'b0;
    reg_write_c     = 1'b0;
    mem_read_c      = 1'b0;
    mem_write_c     = 1'b0;
    instr_done_c    = 1'b0;
    illegal_c       = 1'b0;
    bus.iord        = 1'b0;
    bus.mem_to_reg  = 1'b0;
    bus.reg_dst     = 1'b0;
    bus.alu_src_a   = 1'b0;
    bus.alu_src_b   = SRCB_REG;
    bus.pc_source   = PCSRC_ALU;
    bus.alu_ctrl    = ALU_ADD;
    case (state_q)
      S_IF: begin
        mem_read_c    = 1'b1;
        bus.alu_src_b = SRCB_FOUR;
        ir_write_c    = bus.mem_ready;
        pc_write_c    = bus.mem_ready;
      end
      S_ID: begin
        bus.alu_src_b = SRCB_IMM_SH;
        illegal_c     = id_illegal;
        instr_done_c  = id_illegal;
      end
      S_MEMADR, S_ADDI_EX: begin
        bus.alu_src_a = 1'b1;
        bus.alu_src_b = SRCB_IMM;
      end
      S_MEMRD: begin
        mem_read_c = 1'b1;
        bus.iord   = 1'b1;
      end
      S_MEMWB: begin
        reg_write_c    = 1'b1;
        bus.mem_to_reg = 1'b1;
        instr_done_c   = 1'b1;
      end
      S_MEMWR: begin
        mem_write_c  = 1'b1;
        bus.iord     = 1'b1;
        instr_done_c = bus.mem_ready;
      end
      S_EXE: begin
        bus.alu_src_a = 1'b1;
        bus.alu_ctrl  = dec_alu;
      end
      S_ALUWB: begin
        reg_write_c  = 1'b1;
        bus.reg_dst  = 1'b1;
        instr_done_c = 1'b1;
      end
      S_BRANCH: begin
        bus.alu_src_a   = 1'b1;
        bus.alu_ctrl    = ALU_SUB;
        pc_write_cond_c = 1'b1;
        bus.pc_source   = PCSRC_ALUOUT;
        instr_done_c    = 1'b1;
      end
      S_JUMP: begin
        pc_write_c    = 1'b1;
        bus.pc_source = PCSRC_JUMP;
        instr_done_c  = 1'b1;
      end
      S_ADDI_WB: begin
        reg_write_c  = 1'b1;
        instr_done_c = 1'b1;
      end
      default: ;
    endcase
  end

  // Write-side strobes are killed the instant reset asserts so no partial write lands.
  assign bus.pc_write      = pc_write_c & rst_n;
  assign bus.pc_write_cond = pc_write_cond_c & rst_n;
  assign bus.ir_write      = ir_write_c & rst_n;
  assign bus.reg_write     = reg_write_c & rst_n;
  assign bus.mem_read      = mem_read_c & rst_n;
  assign bus.mem_write     = mem_write_c & rst_n;
  assign bus.instr_done    = instr_done_c & rst_n;
  assign bus.illegal       = illegal_c & rst_n;

  assign state = STATE_W'(state_q);

endmodule

// File: tb/tb_mc_ctrl_fsm.sv
// Directed bench for mc_ctrl_fsm. Expected output vectors are queued as
// stimulus is driven and popped when the DUT outputs are sampled.
// Vector layout: {state[3:0], pc_write, pc_write_cond, iord, mem_read,
//   mem_write, ir_write, mem_to_reg, reg_dst, reg_write, alu_src_a,
//   alu_src_b[1:0], pc_source[1:0], alu_ctrl[2:0], instr_done, illegal}
module tb_mc_ctrl_fsm;

  localparam logic [22:0] E_IF_RST  = {4'd0,  10'b0000000000, 2'b01, 2'b00, 3'b010, 2'b00};
  localparam logic [22:0] E_IF_RDY  = {4'd0,  10'b1001010000, 2'b01, 2'b00, 3'b010, 2'b00};
  localparam logic [22:0] E_IF_WAIT = {4'd0,  10'b0001000000, 2'b01, 2'b00, 3'b010, 2'b00};
  localparam logic [22:0] E_ID      = {4'd1,  10'b0000000000, 2'b11, 2'b00, 3'b010, 2'b00};
  localparam logic [22:0] E_ID_ILL  = {4'd1,  10'b0000000000, 2'b11, 2'b00, 3'b010, 2'b11};
  localparam logic [22:0] E_MEMADR  = {4'd2,  10'b0000000001, 2'b10, 2'b00, 3'b010, 2'b00};
  localparam logic [22:0] E_MEMRD   = {4'd3,  10'b0011000000, 2'b00, 2'b00, 3'b010, 2'b00};
  localparam logic [22:0] E_MEMWB   = {4'd4,  10'b0000001010, 2'b00, 2'b00, 3'b010, 2'b10};
  localparam logic [22:0] E_MEMWR_W = {4'd5,  10'b0010100000, 2'b00, 2'b00, 3'b010, 2'b00};
  localparam logic [22:0] E_MEMWR_R = {4'd5,  10'b0010100000, 2'b00, 2'b00, 3'b010, 2'b10};
  localparam logic [22:0] E_ALUWB   = {4'd7,  10'b0000000110, 2'b00, 2'b00, 3'b010, 2'b10};
  localparam logic [22:0] E_BRANCH  = {4'd8,  10'b0100000001, 2'b00, 2'b01, 3'b110, 2'b10};
  localparam logic [22:0] E_JUMP    = {4'd9,  10'b1000000000, 2'b00, 2'b10, 3'b010, 2'b10};
  localparam logic [22:0] E_ADDI_EX = {4'd10, 10'b0000000001, 2'b10, 2'b00, 3'b010, 2'b00};
  localparam logic [22:0] E_ADDI_WB = {4'd11, 10'b0000000010, 2'b00, 2'b00, 3'b010, 2'b10};

  logic       clk;
  logic       rst_n;
  logic [3:0] state;

  mc_ctrl_fsm_if bus ();

  mc_ctrl_fsm #(.STATE_W(4)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus),
    .state(state)
  );

  int          vectors = 0;
  int          miscompares = 0;
  int          ir_cnt = 0;
  logic [22:0] exp_q[$];
  string       tag_q[$];

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #50000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "bench timeout");
  end

  function automatic logic [22:0] exe_vec(input logic [2:0] alu);
    return {4'd6, 10'b0000000001, 2'b00, 2'b00, alu, 2'b00};
  endfunction

  task automatic push_exp(input logic [22:0] e, input string tag);
    exp_q.push_back(e);
    tag_q.push_back(tag);
  endtask

  task automatic pop_cmp();
    logic [22:0] e;
    logic [22:0] obs;
    string       tag;
    obs = {state, bus.pc_write, bus.pc_write_cond, bus.iord, bus.mem_read,
           bus.mem_write, bus.ir_write, bus.mem_to_reg, bus.reg_dst,
           bus.reg_write, bus.alu_src_a, bus.alu_src_b, bus.pc_source,
           bus.alu_ctrl, bus.instr_done, bus.illegal};
    if (bus.ir_write === 1'b1) ir_cnt++;
    vectors++;
    if (exp_q.size() == 0) begin
      miscompares++;
      $display("FAIL scoreboard_empty observed=%h expected=queued_vector", obs);
    end else begin
      e   = exp_q.pop_front();
      tag = tag_q.pop_front();
      assert (obs === e) else begin
        miscompares++;
        $error("FAIL %s observed=%h expected=%h", tag, obs, e);
      end
    end
  endtask

  // One clock cycle: drive inputs just after the rising edge, check at the falling edge.
  task automatic step(input logic [5:0] op, input logic [5:0] fn, input logic z,
                      input logic mr, input logic [22:0] e, input string tag);
    bus.opcode    = op;
    bus.funct     = fn;
    bus.zero      = z;
    bus.mem_ready = mr;
    push_exp(e, tag);
    @(negedge clk);
    pop_cmp();
    @(posedge clk);
    #1;
  endtask

  logic [5:0] fn_tab[5];
  logic [2:0] alu_tab[5];

  initial begin
    fn_tab  = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h2A};
    alu_tab = '{3'b010, 3'b110, 3'b000, 3'b001, 3'b111};

    rst_n         = 1'b0;
    bus.opcode    = 6'h00;
    bus.funct     = 6'h20;
    bus.zero      = 1'b0;
    bus.mem_ready = 1'b1;
    #3;
    push_exp(E_IF_RST, "rst_hold_a");
    pop_cmp();
    #90;
    push_exp(E_IF_RST, "rst_hold_b");
    pop_cmp();
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // First fetch after release, then sub
    step(6'h00, 6'h22, 1'b0, 1'b1, E_IF_RDY, "rel_if");
    step(6'h00, 6'h22, 1'b0, 1'b1, E_ID, "sub_id");
    step(6'h00, 6'h22, 1'b0, 1'b1, exe_vec(3'b110), "sub_exe");
    step(6'h00, 6'h22, 1'b0, 1'b1, E_ALUWB, "sub_wb");

    // All R-type functs
    for (int i = 0; i < 5; i++) begin
      step(6'h00, fn_tab[i], 1'b0, 1'b1, E_IF_RDY, "rt_if");
      step(6'h00, fn_tab[i], 1'b0, 1'b1, E_ID, "rt_id");
      step(6'h00, fn_tab[i], 1'b0, 1'b1, exe_vec(alu_tab[i]), "rt_exe");
      step(6'h00, fn_tab[i], 1'b0, 1'b1, E_ALUWB, "rt_wb");
    end

    // lw with two wait cycles in fetch and in read: 9 cycles
    ir_cnt = 0;
    step(6'h23, 6'h00, 1'b0, 1'b0, E_IF_WAIT, "lw_if_w1");
    step(6'h23, 6'h00, 1'b0, 1'b0, E_IF_WAIT, "lw_if_w2");
    step(6'h23, 6'h00, 1'b0, 1'b1, E_IF_RDY, "lw_if");
    step(6'h23, 6'h00, 1'b0, 1'b1, E_ID, "lw_id");
    step(6'h23, 6'h00, 1'b0, 1'b1, E_MEMADR, "lw_adr");
    step(6'h23, 6'h00, 1'b0, 1'b0, E_MEMRD, "lw_rd_w1");
    step(6'h23, 6'h00, 1'b0, 1'b0, E_MEMRD, "lw_rd_w2");
    step(6'h23, 6'h00, 1'b0, 1'b1, E_MEMRD, "lw_rd");
    step(6'h23, 6'h00, 1'b0, 1'b1, E_MEMWB, "lw_wb");
    vectors++;
    assert (ir_cnt === 1) else begin
      miscompares++;
      $error("FAIL lw_ir_pulses observed=%0d expected=1", ir_cnt);
    end

    // sw zero-wait
    step(6'h2B, 6'h00, 1'b0, 1'b1, E_IF_RDY, "sw_if");
    step(6'h2B, 6'h00, 1'b0, 1'b1, E_ID, "sw_id");
    step(6'h2B, 6'h00, 1'b0, 1'b1, E_MEMADR, "sw_adr");
    step(6'h2B, 6'h00, 1'b0, 1'b1, E_MEMWR_R, "sw_wr");

    // addi
    step(6'h08, 6'h00, 1'b0, 1'b1, E_IF_RDY, "addi_if");
    step(6'h08, 6'h00, 1'b0, 1'b1, E_ID, "addi_id");
    step(6'h08, 6'h00, 1'b0, 1'b1, E_ADDI_EX, "addi_ex");
    step(6'h08, 6'h00, 1'b0, 1'b1, E_ADDI_WB, "addi_wb");

    // beq taken and not taken, then j
    step(6'h04, 6'h00, 1'b1, 1'b1, E_IF_RDY, "beq1_if");
    step(6'h04, 6'h00, 1'b1, 1'b1, E_ID, "beq1_id");
    step(6'h04, 6'h00, 1'b1, 1'b1, E_BRANCH, "beq1_br");
    step(6'h04, 6'h00, 1'b0, 1'b1, E_IF_RDY, "beq0_if");
    step(6'h04, 6'h00, 1'b0, 1'b1, E_ID, "beq0_id");
    step(6'h04, 6'h00, 1'b0, 1'b1, E_BRANCH, "beq0_br");
    step(6'h02, 6'h00, 1'b0, 1'b1, E_IF_RDY, "j_if");
    step(6'h02, 6'h00, 1'b0, 1'b1, E_ID, "j_id");
    step(6'h02, 6'h00, 1'b0, 1'b1, E_JUMP, "j_jump");

    // Illegal opcode, then illegal funct
    step(6'h3F, 6'h00, 1'b0, 1'b1, E_IF_RDY, "ill_op_if");
    step(6'h3F, 6'h00, 1'b0, 1'b1, E_ID_ILL, "ill_op_id");
    step(6'h00, 6'h27, 1'b0, 1'b1, E_IF_RDY, "ill_fn_if");
    step(6'h00, 6'h27, 1'b0, 1'b1, E_ID_ILL, "ill_fn_id");
    step(6'h00, 6'h27, 1'b0, 1'b0, E_IF_WAIT, "ill_fn_back");

    // Store interrupted by reset while waiting on memory
    step(6'h2B, 6'h00, 1'b0, 1'b1, E_IF_RDY, "rs_if");
    step(6'h2B, 6'h00, 1'b0, 1'b1, E_ID, "rs_id");
    step(6'h2B, 6'h00, 1'b0, 1'b1, E_MEMADR, "rs_adr");
    step(6'h2B, 6'h00, 1'b0, 1'b0, E_MEMWR_W, "rs_wr_w");
    #2;
    rst_n = 1'b0;
    push_exp(E_IF_RST, "rs_async");
    #1;
    pop_cmp();
    @(posedge clk);
    #1;
    push_exp(E_IF_RST, "rs_held");
    pop_cmp();
    rst_n = 1'b1;
    step(6'h02, 6'h00, 1'b0, 1'b1, E_IF_RDY, "rec_if");
    step(6'h02, 6'h00, 1'b0, 1'b1, E_ID, "rec_id");
    step(6'h02, 6'h00, 1'b0, 1'b1, E_JUMP, "rec_jump");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
